// File: rtl/rom32x4_burst_reader.sv
// rom32x4_burst_reader: address sequencer and nibble packer for a 32x4 ROM.
// Walks LEN addresses from BASE and emits packed words on valid/ready.
module rom32x4_burst_reader #(
    parameter int NIB_PER_WORD = 4,
    parameter int ROM_LAT      = 1
) (
    input  logic                      i_ck,
    input  logic                      i_rstn,
    input  logic                      i_start,
    input  logic [4:0]                i_base,
    input  logic [5:0]                i_len,
    output logic [4:0]                o_ad,
    input  logic [3:0]                i_qdo,
    output logic [4*NIB_PER_WORD-1:0] o_dout,
    output logic                      o_dout_vld,
    input  logic                      i_out_rdy,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int W  = 4 * NIB_PER_WORD;
    localparam int CW = $clog2(NIB_PER_WORD);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NIB_PER_WORD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    r_state;
    logic [4:0]    r_ptr;
    logic [5:0]    r_rem;
    logic          r_tag;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_pack;
    logic [W-1:0]  r_dout;
    logic          r_vld;
    logic          r_busy;
    logic          r_done;

    logic          w_stall;
    logic          w_free;
    logic          w_xfer;
    logic          w_issue;
    logic          w_cap;
    logic          w_inflight;
    logic          w_full_ld;
    logic          w_part_ld;
    logic          w_ld;
    logic          w_end;
    logic [5:0]    w_len;
    logic [W-1:0]  w_word;

    // Unfilled packer slots are kept at zero, so a partial word needs no masking.
    always_comb begin
        w_len      = (i_len > 6'd32) ? 6'd32 : i_len;
        w_stall    = r_vld & ~i_out_rdy;
        w_free     = ~w_stall;
        w_xfer     = r_vld & i_out_rdy;
        w_issue    = (r_state == S_RUN) && (r_rem != 6'd0) && !w_stall;
        w_inflight = (ROM_LAT != 0) ? r_tag : 1'b0;
        w_cap      = (ROM_LAT != 0) ? r_tag : w_issue;
        w_word     = r_pack | (W'(i_qdo) << (4 * r_cnt));
        w_full_ld  = w_cap && (r_cnt == LAST_SLOT);
        w_part_ld  = (r_state == S_FLUSH) && !w_inflight
                     && (r_cnt != '0) && w_free;
        w_ld       = w_full_ld | w_part_ld;
        w_end      = (r_state != S_IDLE) && (r_rem == 6'd0) && !w_inflight
                     && (r_cnt == '0) && w_free;
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_tag   <= 1'b0;
            r_cnt   <= '0;
            r_pack  <= '0;
            r_dout  <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ptr   <= i_base;
                        r_rem   <= w_len;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_end) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_rem == 6'd0) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_end) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_ptr <= r_ptr + 5'd1;
                r_rem <= r_rem - 6'd1;
            end
            r_tag <= (ROM_LAT != 0) && w_issue;

            if (w_ld) begin
                r_pack <= '0;
                r_cnt  <= '0;
            end else if (w_cap) begin
                r_pack <= w_word;
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_ld) begin
                r_dout <= w_full_ld ? w_word : r_pack;
                r_vld  <= 1'b1;
            end else if (w_xfer) begin
                r_vld  <= 1'b0;
            end
        end
    end

    // Issue throttling must keep a completed word from hitting a stalled output.
    a_no_overrun: assert property (
        @(posedge i_ck) disable iff (!i_rstn) w_full_ld |-> w_free);

    assign o_ad       = r_ptr;
    assign o_dout     = r_dout;
    assign o_dout_vld = r_vld;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_rom32x4_burst_reader.sv
// Bench for rom32x4_burst_reader: table vectors, corner sequences and
// randomized bursts against a nibble-level reference model.
module tb_rom32x4_burst_reader;
    localparam int N       = 4;
    localparam int M_ALW   = 0;
    localparam int M_STALL = 1;
    localparam int M_RND   = 2;

    typedef struct {
        logic [4:0]  base;
        logic [5:0]  len;
        int          mode;
        bit          mid;
        int          n;
        logic [15:0] first;
        logic [15:0] last;
        logic [4:0]  ptr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        rdy0 = 1'b1;
    logic        rdy1 = 1'b1;
    logic [4:0]  base = '0;
    logic [5:0]  len = '0;
    logic [4:0]  ad0, ad1;
    logic [3:0]  q0, q1;
    logic [15:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1, done0, done1;
    logic [3:0]  rom [32];
    logic [15:0] mdl [$];
    vec_t        tbl [8];
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) q0 <= rom[ad0];
    assign q1 = rom[ad1];

    rom32x4_burst_reader #(.NIB_PER_WORD(N), .ROM_LAT(1)) u0 (
        .i_ck(clk), .i_rstn(rstn), .i_start(start0), .i_base(base),
        .i_len(len), .o_ad(ad0), .i_qdo(q0), .o_dout(dout0),
        .o_dout_vld(vld0), .i_out_rdy(rdy0), .o_busy(busy0), .o_done(done0));

    rom32x4_burst_reader #(.NIB_PER_WORD(N), .ROM_LAT(0)) u1 (
        .i_ck(clk), .i_rstn(rstn), .i_start(start1), .i_base(base),
        .i_len(len), .o_ad(ad1), .i_qdo(q1), .o_dout(dout1),
        .o_dout_vld(vld1), .i_out_rdy(rdy1), .o_busy(busy1), .o_done(done1));

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic build_model(input logic [4:0] b, input logic [5:0] l);
        int n;
        logic [15:0] w;
        n = (l > 6'd32) ? 32 : int'(l);
        mdl.delete();
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[4*(k%N) +: 4] = rom[(int'(b) + k) % 32];
            if ((k % N == N - 1) || (k == n - 1)) begin
                mdl.push_back(w);
                w = '0;
            end
        end
    endtask

    task automatic run_burst(input string nm, input logic [4:0] b,
                             input logic [5:0] l, input int mode,
                             input bit mid, input bit use_exp,
                             input int exp_n, input logic [15:0] exp_first,
                             input logic [15:0] exp_last,
                             input logic [4:0] exp_ptr);
        logic [15:0] got [$];
        logic [4:0]  ads [$];
        int          c, dones, done_c, frz_bad, nl, bad;
        bit          prev_stall;
        logic [4:0]  prev_ad, ptr_end;
        build_model(b, l);
        nl = (l > 6'd32) ? 32 : int'(l);
        ptr_end = 5'((int'(b) + nl) % 32);
        @(negedge clk);
        base = b; len = l; start0 = 1'b1; rdy0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        c = 0; dones = 0; done_c = -1; frz_bad = 0;
        prev_stall = 1'b0; prev_ad = ad0;
        while (dones == 0 && c < 400) begin
            if (mid && c == 3) begin
                start0 = 1'b1; base = 5'd20; len = 6'd4;
            end else begin
                start0 = 1'b0;
            end
            case (mode)
                M_STALL: rdy0 = !(c >= 6 && c <= 20);
                M_RND:   rdy0 = ($urandom_range(0, 9) < 7);
                default: rdy0 = 1'b1;
            endcase
            if (ads.size() == 0 || ads[ads.size()-1] != ad0)
                ads.push_back(ad0);
            if (prev_stall && ad0 != prev_ad) frz_bad++;
            prev_stall = vld0 && !rdy0;
            prev_ad = ad0;
            if (vld0 && rdy0) got.push_back(dout0);
            @(posedge clk); #1;
            if (done0) begin
                dones = 1; done_c = c;
            end
            @(negedge clk);
            c++;
        end
        start0 = 1'b0;
        rdy0 = 1'b1;
        chk({nm, ":done_seen"}, dones, 1);
        chk({nm, ":busy_low"}, busy0, 1'b0);
        if (l == 6'd0) chk({nm, ":len0_done_cycle"}, done_c, 0);
        chk({nm, ":nwords"}, got.size(), mdl.size());
        for (int i = 0; i < mdl.size(); i++)
            chk($sformatf("%s:word%0d", nm, i),
                (i < got.size()) ? got[i] : 16'hxxxx, mdl[i]);
        bad = 0;
        if (ads.size() == nl + 1)
            for (int i = 0; i <= nl; i++)
                if (ads[i] != 5'((int'(b) + i) % 32)) bad++;
        chk({nm, ":ad_seq_len"}, ads.size(), nl + 1);
        chk({nm, ":ad_seq_vals"}, bad, 0);
        chk({nm, ":ad_frozen"}, frz_bad, 0);
        chk({nm, ":ptr_end"}, ad0, ptr_end);
        if (use_exp) begin
            chk({nm, ":tbl_n"}, got.size(), exp_n);
            chk({nm, ":tbl_ptr"}, ad0, exp_ptr);
            if (exp_n > 0) begin
                chk({nm, ":tbl_first"},
                    (got.size() > 0) ? got[0] : 16'hxxxx, exp_first);
                chk({nm, ":tbl_last"},
                    (got.size() > 0) ? got[got.size()-1] : 16'hxxxx, exp_last);
            end
        end
        @(posedge clk); #1;
        chk({nm, ":done_one_cycle"}, done0, 1'b0);
        chk({nm, ":vld_idle"}, vld0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int first, dn;
        logic [15:0] w;
        tbl[0] = '{5'd0,  6'd4,  M_ALW,   1'b0, 1, 16'h3210, 16'h3210, 5'd4};
        tbl[1] = '{5'd30, 6'd4,  M_ALW,   1'b0, 1, 16'h10FE, 16'h10FE, 5'd2};
        tbl[2] = '{5'd5,  6'd6,  M_ALW,   1'b0, 2, 16'h8765, 16'h00A9, 5'd11};
        tbl[3] = '{5'd0,  6'd12, M_STALL, 1'b0, 3, 16'h3210, 16'hBA98, 5'd12};
        tbl[4] = '{5'd7,  6'd0,  M_ALW,   1'b0, 0, 16'h0000, 16'h0000, 5'd7};
        tbl[5] = '{5'd0,  6'd8,  M_ALW,   1'b1, 2, 16'h3210, 16'h7654, 5'd8};
        tbl[6] = '{5'd3,  6'd40, M_ALW,   1'b0, 8, 16'h6543, 16'h210F, 5'd3};
        tbl[7] = '{5'd17, 6'd9,  M_RND,   1'b0, 3, 16'h4321, 16'h0009, 5'd26};
        for (int i = 0; i < 32; i++) rom[i] = 4'(i);

        repeat (2) @(negedge clk);
        chk("rst:ad", ad0, 5'd0);
        chk("rst:dout", dout0, 16'h0);
        chk("rst:vld", vld0, 1'b0);
        chk("rst:busy", busy0, 1'b0);
        chk("rst:done", done0, 1'b0);
        chk("rst:busy_lat0", busy1, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        base = 5'd0; len = 6'd4; rdy0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        first = -1; dn = 0; w = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (vld0 && first < 0) begin first = k; w = dout0; end
            if (done0) dn++;
        end
        chk("lat1:first_valid", first, 5);
        chk("lat1:word", w, 16'h3210);
        chk("lat1:done", dn, 1);

        @(negedge clk);
        base = 5'd0; len = 6'd4; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        first = -1; dn = 0; w = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (vld1 && first < 0) begin first = k; w = dout1; end
            if (done1) dn++;
        end
        chk("lat0:first_valid", first, 4);
        chk("lat0:word", w, 16'h3210);
        chk("lat0:done", dn, 1);
        chk("lat0:ptr_end", ad1, 5'd4);
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_burst($sformatf("vec%0d", i), tbl[i].base, tbl[i].len,
                      tbl[i].mode, tbl[i].mid, 1'b1, tbl[i].n,
                      tbl[i].first, tbl[i].last, tbl[i].ptr);

        @(negedge clk);
        base = 5'd0; len = 6'd8; rdy0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst:ad", ad0, 5'd0);
        chk("midrst:dout", dout0, 16'h0);
        chk("midrst:vld", vld0, 1'b0);
        chk("midrst:busy", busy0, 1'b0);
        chk("midrst:done", done0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        run_burst("post_rst", 5'd3, 6'd4, M_ALW, 1'b0, 1'b1, 1,
                  16'h6543, 16'h6543, 5'd7);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 32; i++) rom[i] = 4'($urandom_range(0, 15));
            run_burst($sformatf("rnd%0d", r), 5'($urandom_range(0, 31)),
                      6'($urandom_range(0, 40)), M_RND,
                      ($urandom_range(0, 3) == 0), 1'b0, 0,
                      16'h0, 16'h0, 5'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
